// File: rtl/vga_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_fetch
// Purpose  : 640x480@60 VGA timing generator and frame-buffer read-address
//            generator for an IMG_W x IMG_H image upscaled by 2^SCALE_SH into
//            a window at (X0,Y0). Coordinate and sync outputs are delayed by
//            RD_LAT pixel slots so they line up with returning RAM data.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_fetch #(
    parameter int IMG_W    = 100,
    parameter int IMG_H    = 100,
    parameter int SCALE_SH = 2,
    parameter int X0       = 120,
    parameter int Y0       = 40,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = 14,
    // Raster timing; defaults are the standard 640x480@60 values.
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic [9:0]        x_out,
    output logic [9:0]        y_out,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic              frame_start
);

    localparam logic [9:0] c_H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_H_VIS    = 10'(H_VIS);
    localparam logic [9:0] c_V_VIS    = 10'(V_VIS);
    localparam logic [9:0] c_HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] c_X_FIRST  = 10'(X0);
    localparam logic [9:0] c_X_END    = 10'(X0 + (IMG_W << SCALE_SH));
    localparam logic [9:0] c_X_LAST   = 10'(X0 + (IMG_W << SCALE_SH) - 1);
    localparam logic [9:0] c_Y_FIRST  = 10'(Y0);
    localparam logic [9:0] c_Y_END    = 10'(Y0 + (IMG_H << SCALE_SH));

    // Sub-counters count screen pixels/lines within one image pixel; keep at
    // least one bit so SCALE_SH=0 still elaborates.
    localparam int                 c_SUB_W     = (SCALE_SH > 0) ? SCALE_SH : 1;
    localparam logic [c_SUB_W-1:0] c_SUB_MAX   = c_SUB_W'((1 << SCALE_SH) - 1);
    localparam logic [c_SUB_W-1:0] c_SUB_FIRST = c_SUB_W'((SCALE_SH > 0) ? 1 : 0);
    localparam logic [ADDR_W-1:0]  c_ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0]  c_ADDR_ONE  = ADDR_W'(1);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
    } pix_info_t;

    localparam pix_info_t c_FLUSH = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b0};

    logic [9:0]         r_h_cnt;
    logic [9:0]         r_v_cnt;
    logic [ADDR_W-1:0]  r_row_base;
    logic [c_SUB_W-1:0] r_col_sub;
    logic [c_SUB_W-1:0] r_line_sub;
    pix_info_t          r_pipe [RD_LAT];

    logic [9:0]         w_h_nxt;
    logic [9:0]         w_v_nxt;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_nxt_win;
    logic               w_row_end;
    pix_info_t          w_cur;

    // Next raster position and window membership of the position being entered.
    always_comb begin
        w_h_wrap  = (r_h_cnt == c_H_LAST);
        w_v_wrap  = (r_v_cnt == c_V_LAST);
        w_h_nxt   = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
        w_v_nxt   = w_h_wrap ? (w_v_wrap ? 10'd0 : r_v_cnt + 10'd1) : r_v_cnt;
        w_nxt_win = (w_h_nxt >= c_X_FIRST) && (w_h_nxt < c_X_END) &&
                    (w_v_nxt >= c_Y_FIRST) && (w_v_nxt < c_Y_END);
        // Leaving the last window column of a window line.
        w_row_end = (r_h_cnt == c_X_LAST) &&
                    (r_v_cnt >= c_Y_FIRST) && (r_v_cnt < c_Y_END);
    end

    // Raster counters and incremental (multiplier-free) read address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt    <= 10'd0;
            r_v_cnt    <= 10'd0;
            r_row_base <= '0;
            r_col_sub  <= '0;
            r_line_sub <= '0;
            ram_addr   <= '0;
            ram_rd_en  <= 1'b0;
        end else if (pix_en) begin
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;

            if (w_nxt_win) begin
                ram_rd_en <= 1'b1;
                if (w_h_nxt == c_X_FIRST) begin
                    ram_addr  <= r_row_base;
                    r_col_sub <= c_SUB_FIRST;
                end else begin
                    if (r_col_sub == '0) begin
                        ram_addr <= ram_addr + c_ADDR_ONE;
                    end
                    r_col_sub <= (r_col_sub == c_SUB_MAX) ? '0 : r_col_sub + c_SUB_W'(1);
                end
            end else begin
                ram_rd_en <= 1'b0;
            end

            // Row base advances one image row every 2^SCALE_SH window lines and
            // returns to the top of the image when the frame wraps.
            if (w_h_wrap && w_v_wrap) begin
                r_row_base <= '0;
                r_line_sub <= '0;
            end else if (w_row_end) begin
                if (r_line_sub == c_SUB_MAX) begin
                    r_line_sub <= '0;
                    r_row_base <= r_row_base + c_ROW_STEP;
                end else begin
                    r_line_sub <= r_line_sub + c_SUB_W'(1);
                end
            end
        end
    end

    // Coordinate and sync attributes of the current raster position.
    always_comb begin
        w_cur = '{x:  r_h_cnt,
                  y:  r_v_cnt,
                  hs: !((r_h_cnt >= c_HS_FIRST) && (r_h_cnt < c_HS_END)),
                  vs: !((r_v_cnt >= c_VS_FIRST) && (r_v_cnt < c_VS_END)),
                  vo: (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS)};
    end

    // Delay line matching the RAM read latency, advancing only on pixel slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_pipe[k] <= c_FLUSH;
            end
        end else if (pix_en) begin
            r_pipe[0] <= w_cur;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    // Single-clock pulse on the edge where the raster returns to (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && w_h_wrap && w_v_wrap;
        end
    end

    assign x_out    = r_pipe[RD_LAT-1].x;
    assign y_out    = r_pipe[RD_LAT-1].y;
    assign hsync    = r_pipe[RD_LAT-1].hs;
    assign vsync    = r_pipe[RD_LAT-1].vs;
    assign video_on = r_pipe[RD_LAT-1].vo;

endmodule
`default_nettype wire
